// File: rtl/inst_mem_loader_pkg.sv
// inst_mem_loader_pkg: loader FSM encoding and default load address shared with memory and bench
package inst_mem_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE} state_e;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;
endpackage

// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: byte stream in, instruction-memory write port out
interface inst_mem_loader_if #(parameter int ADDR_W = 32);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  modport master (output byte_valid, byte_data, input byte_ready, mem_we, mem_addr, mem_wdata);
  modport slave (input byte_valid, byte_data, output byte_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/inst_mem_loader_word_assembler.sv
// word_assembler: packs accepted bytes little-endian into a 32-bit word
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  always_comb begin
    word_d = word_q;
    if (en && !clear) word_d[8*byte_cnt_q +: 8] = byte_in;
    byte_cnt_d = clear ? 2'd0 : en ? byte_cnt_q + 2'd1 : byte_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      byte_cnt_q <= '0;
      word_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q <= word_d;
    end
  assign word = word_q;
  assign word_full = en && !clear && byte_cnt_q == 2'd3;
endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: boot-time loader writing a length-prefixed byte stream into instruction memory
module inst_mem_loader import inst_mem_loader_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          ADDR_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  inst_mem_loader_if.slave         bus,
  output logic                     busy,
  output logic                     done,
  output logic                     cpu_hold,
  output logic [15:0]              words_written
);
  state_e            state_q, state_d;
  logic [15:0]       n_q, n_d, words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              accept, clear, word_full;
  logic [31:0]       word;
  assign accept = bus.byte_valid && bus.byte_ready;
  word_assembler u_asm (
    .clk, .rst, .clear,
    .en(accept && state_q == DATA),
    .byte_in(bus.byte_data),
    .word, .word_full
  );
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    addr_d = addr_q;
    words_d = words_q;
    clear = 1'b0;
    case (state_q)
      IDLE, DONE: if (start && !abort) begin
        state_d = LEN0;
        addr_d = ADDR_W'(BASE_ADDR);
        words_d = '0;
        clear = 1'b1;
      end
      LEN0: if (accept) begin
        n_d[7:0] = bus.byte_data;
        state_d = LEN1;
      end
      LEN1: if (accept) begin
        n_d[15:8] = bus.byte_data;
        state_d = {bus.byte_data, n_q[7:0]} == 16'd0 ? DONE : DATA;
      end
      DATA: if (word_full) state_d = WRITE;
      WRITE: begin
        addr_d = addr_q + ADDR_W'(4);
        words_d = words_q + 16'd1;
        clear = 1'b1;
        state_d = words_d == n_q ? DONE : DATA;
      end
      default: state_d = IDLE;
    endcase
    // abort keeps what was already written but drops the word in flight
    if (abort && busy) begin
      state_d = IDLE;
      addr_d = addr_q;
      words_d = words_q;
      clear = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      addr_q <= ADDR_W'(BASE_ADDR);
      words_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      addr_q <= addr_d;
      words_q <= words_d;
    end
  assign busy = state_q inside {LEN0, LEN1, DATA, WRITE};
  assign done = state_q == DONE;
  assign cpu_hold = state_q != DONE;
  assign words_written = words_q;
  assign bus.byte_ready = state_q inside {LEN0, LEN1, DATA};
  assign bus.mem_we = state_q == WRITE && !abort;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = word;
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed checks of the instruction-memory loader
module tb_inst_mem_loader;
  import inst_mem_loader_pkg::*;
  localparam logic [79:0] NOM = 80'hE3A0_1A01_E3A0_0014_0002;
  localparam logic [79:0] ONE = 80'h0000_0000_EAFF_FFFF_0001;
  localparam logic [79:0] ABW = 80'h0000_0000_1234_5678_0001;
  logic clk = 1'b0;
  logic rst, start, abort, busy, done, cpu_hold;
  logic [15:0] words_written;
  int n_chk = 0, n_fail = 0, nr_cnt = 0, b, nr0;
  logic [31:0] wa[$], wd[$];
  inst_mem_loader_if bus ();
  inst_mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bus(bus.slave),
    .busy(busy), .done(done), .cpu_hold(cpu_hold), .words_written(words_written)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
    if (busy && !bus.byte_ready) nr_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  task automatic send_stream(input logic [79:0] s, input int first, input int n, input int gap);
    for (int i = first; i < first + n; i++) begin
      int w;
      w = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data = s[8*i +: 8];
      while (!bus.byte_ready && w < 50) begin
        tick;
        w++;
      end
      chk("byte_ready_timeout", 32'(w < 50), 32'd1);
      tick;
      bus.byte_valid = 1'b0;
      repeat (gap) tick;
    end
  endtask
  task automatic chk_nominal(input string tag, input int base);
    chk({tag, "_nwr"}, 32'(wa.size() - base), 32'd2);
    chk({tag, "_a0"}, wa[base], 32'h0);
    chk({tag, "_d0"}, wd[base], 32'hE3A00014);
    chk({tag, "_a1"}, wa[base+1], 32'h4);
    chk({tag, "_d1"}, wd[base+1], 32'hE3A01A01);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_words"}, 32'(words_written), 32'd2);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    bus.byte_valid = 1'b0; bus.byte_data = 8'h00;
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", bus.mem_addr, DEF_BASE_ADDR);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_words", 32'(words_written), 32'd0);
    repeat (2) tick;
    rst = 1'b0;
    tick;
    b = wa.size();
    pulse_start;
    chk("nom_busy", 32'(busy), 32'd1);
    chk("nom_ready", 32'(bus.byte_ready), 32'd1);
    send_stream(NOM, 0, 10, 0);
    tick;
    chk_nominal("nom", b);
    b = wa.size();
    pulse_start;
    chk("zero_done_drop", 32'(done), 32'd0);
    send_stream(80'h0, 0, 2, 0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_hold", 32'(cpu_hold), 32'd0);
    chk("zero_words", 32'(words_written), 32'd0);
    tick;
    chk("zero_nwr", 32'(wa.size() - b), 32'd0);
    b = wa.size();
    nr0 = nr_cnt;
    pulse_start;
    send_stream(NOM, 0, 10, 3);
    tick;
    chk_nominal("gap", b);
    chk("gap_notready", 32'(nr_cnt - nr0), 32'd2);
    b = wa.size();
    pulse_start;
    send_stream(NOM, 0, 7, 0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abd_nwr", 32'(wa.size() - b), 32'd1);
    chk("abd_a0", wa[b], 32'h0);
    chk("abd_d0", wd[b], 32'hE3A00014);
    chk("abd_busy", 32'(busy), 32'd0);
    chk("abd_done", 32'(done), 32'd0);
    chk("abd_hold", 32'(cpu_hold), 32'd1);
    chk("abd_words", 32'(words_written), 32'd1);
    b = wa.size();
    pulse_start;
    send_stream(NOM, 0, 10, 0);
    tick;
    chk_nominal("abd_reload", b);
    b = wa.size();
    pulse_start;
    send_stream(ABW, 0, 6, 0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abw_nwr", 32'(wa.size() - b), 32'd0);
    chk("abw_words", 32'(words_written), 32'd0);
    chk("abw_busy", 32'(busy), 32'd0);
    chk("abw_hold", 32'(cpu_hold), 32'd1);
    pulse_start;
    send_stream(NOM, 0, 8, 0);
    chk("ar_pre_words", 32'(words_written), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ready", 32'(bus.byte_ready), 32'd0);
    chk("ar_hold", 32'(cpu_hold), 32'd1);
    chk("ar_words", 32'(words_written), 32'd0);
    chk("ar_addr", bus.mem_addr, 32'h0);
    chk("ar_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk) rst = 1'b0;
    tick;
    b = wa.size();
    pulse_start;
    send_stream(NOM, 0, 10, 0);
    tick;
    chk_nominal("ar_reload", b);
    b = wa.size();
    pulse_start;
    chk("re_done_drop", 32'(done), 32'd0);
    chk("re_hold", 32'(cpu_hold), 32'd1);
    send_stream(ONE, 0, 6, 0);
    tick;
    chk("re_nwr", 32'(wa.size() - b), 32'd1);
    chk("re_a0", wa[b], 32'h0);
    chk("re_d0", wd[b], 32'hEAFFFFFF);
    chk("re_done", 32'(done), 32'd1);
    chk("re_words", 32'(words_written), 32'd1);
    chk("re_hold_end", 32'(cpu_hold), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
